// File: rtl/quant_sched_ctrl.sv
// quant_sched_ctrl: sequences one 8x8 block at a time through the quantiser divide datapath.
// Optional feature macro QUANT_SCHED_QSCALE_GUARD_EN: a sampled slice scale <= 0 is replaced
// by 1 and QS_ERR is raised until reset; without it the scale passes through and QS_ERR is 0.
module quant_sched_ctrl #(
    parameter int CNT_W  = 8,
    parameter int DP_LAT = 1
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic               IN_LAST,
    input  logic               IN_CHROMA,
    input  logic signed [31:0] QSCALE_IN,
    input  logic signed [31:0] QMAT_LUMA   [8][8],
    input  logic signed [31:0] QMAT_CHROMA [8][8],
    output logic signed [31:0] DP_QSCALE,
    output logic signed [31:0] DP_QMAT     [8][8],
    output logic               DP_CAPTURE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               OUT_LAST,
    output logic [CNT_W-1:0]   BLK_CNT,
    output logic               QS_ERR
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [2:0]         lat_q, lat_d;
    logic               last_q, last_d;
    logic signed [31:0] scale_q, scale_d;
    logic signed [31:0] qmat_q [8][8];
    logic signed [31:0] qmat_d [8][8];
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               qs_err_q, qs_err_d;
    logic               in_ready_q, in_ready_d;
    logic               dp_capture_q, dp_capture_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               accept;
    logic               qs_bad;
    logic signed [31:0] qs_new;

`ifdef QUANT_SCHED_QSCALE_GUARD_EN
    assign qs_bad = QSCALE_IN <= 32'sd0;
`else
    assign qs_bad = 1'b0;
`endif
    assign qs_new = qs_bad ? 32'sd1 : QSCALE_IN;
    assign accept = IN_VALID && in_ready_q;

    // Sequencer: accept, present operands, count datapath latency, hold result until taken
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        last_d    = last_q;
        scale_d   = scale_q;
        qmat_d    = qmat_q;
        blk_cnt_d = blk_cnt_q;
        qs_err_d  = qs_err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = ISSUE;
                last_d  = IN_LAST;
                if (IN_CHROMA) qmat_d = QMAT_CHROMA;
                else qmat_d = QMAT_LUMA;
                if (blk_cnt_q == '0) begin
                    scale_d  = qs_new;
                    qs_err_d = qs_err_q | qs_bad;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = 3'(DP_LAT);
            end
            WAIT: if (lat_q == 3'd1) state_d = HOLD;
                  else lat_d = lat_q - 3'd1;
            HOLD: if (OUT_READY) begin
                state_d   = IDLE;
                blk_cnt_d = last_q ? '0 : blk_cnt_q + 1'b1;
            end
        endcase
        in_ready_d   = state_d == IDLE;
        dp_capture_d = state_d == WAIT && lat_d == 3'd1;
        out_valid_d  = state_d == HOLD;
        out_last_d   = state_d == HOLD && last_d;
    end

    // State and registered outputs; reset abandons any block in flight
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            last_q       <= 1'b0;
            scale_q      <= '0;
            qmat_q       <= '{default: '0};
            blk_cnt_q    <= '0;
            qs_err_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            dp_capture_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            last_q       <= last_d;
            scale_q      <= scale_d;
            qmat_q       <= qmat_d;
            blk_cnt_q    <= blk_cnt_d;
            qs_err_q     <= qs_err_d;
            in_ready_q   <= in_ready_d;
            dp_capture_q <= dp_capture_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign IN_READY   = in_ready_q;
    assign DP_QSCALE  = scale_q;
    assign DP_QMAT    = qmat_q;
    assign DP_CAPTURE = dp_capture_q;
    assign OUT_VALID  = out_valid_q;
    assign OUT_LAST   = out_last_q;
    assign BLK_CNT    = blk_cnt_q;
    assign QS_ERR     = qs_err_q;
endmodule
